// File: rtl/approx_max_tracker_pkg.sv
// Shared widths, FSM state type and the comparator's approximation key for approx_max_tracker.
package approx_cmp_pkg;

    localparam int DATA_W = 16;
    localparam int IDX_W  = 8;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // The low byte collapses to a single "nonzero" flag, so samples that differ
    // only below bit 8 can compare as equal.
    function automatic logic [8:0] approx_key(input logic [DATA_W-1:0] v);
        return {v[DATA_W-1:8], |v[7:0]};
    endfunction

endpackage

// File: rtl/approx_max_tracker_cmp.sv
// Approximate 16-bit magnitude comparator; exactly one of EQ/GT/LT is high.
module approx_comparator_16_bit
    import approx_cmp_pkg::*;
(
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    output logic              EQ,
    output logic              GT,
    output logic              LT
);

    logic [8:0] key_a;
    logic [8:0] key_b;

    always_comb begin
        key_a = approx_key(A);
        key_b = approx_key(B);
        GT    = key_a > key_b;
        LT    = key_a < key_b;
        EQ    = key_a == key_b;
    end

endmodule

// File: rtl/approx_max_tracker.sv
// Tracks the approximate maximum of each FRAME_LEN-sample frame, its first position and tie count.
module approx_max_tracker
    import approx_cmp_pkg::*;
#(
    parameter int FRAME_LEN = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_max,
    output logic [IDX_W-1:0]  out_idx,
    output logic [IDX_W-1:0]  out_ties
);

    localparam int CNT_W = 9;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]  max_q, max_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [IDX_W-1:0]   ties_q, ties_d;
    logic               out_valid_q, out_valid_d;
    logic [DATA_W-1:0]  out_max_q, out_max_d;
    logic [IDX_W-1:0]   out_idx_q, out_idx_d;
    logic [IDX_W-1:0]   out_ties_q, out_ties_d;

    logic               cmp_eq, cmp_gt, cmp_lt;
    logic               accept;
    logic [CNT_W-1:0]   cnt_inc;

    approx_comparator_16_bit u_cmp (
        .A  (in_data),
        .B  (max_q),
        .EQ (cmp_eq),
        .GT (cmp_gt),
        .LT (cmp_lt)
    );

    assign in_ready  = (state_q != ST_DONE);
    assign out_valid = out_valid_q;
    assign out_max   = out_max_q;
    assign out_idx   = out_idx_q;
    assign out_ties  = out_ties_q;

    assign accept  = in_valid && in_ready;
    assign cnt_inc = cnt_q + CNT_W'(1);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        max_d       = max_q;
        idx_d       = idx_q;
        ties_d      = ties_q;
        out_valid_d = out_valid_q;
        out_max_d   = out_max_q;
        out_idx_d   = out_idx_q;
        out_ties_d  = out_ties_q;

        case (state_q)
            ST_LOAD: begin
                if (accept) begin
                    max_d   = in_data;
                    idx_d   = '0;
                    ties_d  = '0;
                    cnt_d   = CNT_W'(1);
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (accept) begin
                    cnt_d = cnt_inc;
                    // Multi-hot resolves GT > EQ > LT; all-zero falls through as LT.
                    casez ({cmp_gt, cmp_eq, cmp_lt})
                        3'b1??: begin
                            max_d  = in_data;
                            idx_d  = cnt_q[IDX_W-1:0];
                            ties_d = '0;
                        end
                        3'b01?: ties_d = ties_q + IDX_W'(1);
                        default: ;
                    endcase
                    if (cnt_inc == LAST_CNT) begin
                        state_d     = ST_DONE;
                        out_valid_d = 1'b1;
                        out_max_d   = max_d;
                        out_idx_d   = idx_d;
                        out_ties_d  = ties_d;
                    end
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d     = ST_LOAD;
                    cnt_d       = '0;
                    out_valid_d = 1'b0;
                end
            end
            default: state_d = ST_LOAD;
        endcase

        if (frame_clr) begin
            state_d     = ST_LOAD;
            cnt_d       = '0;
            ties_d      = '0;
            idx_d       = '0;
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_LOAD;
            cnt_q       <= '0;
            max_q       <= '0;
            idx_q       <= '0;
            ties_q      <= '0;
            out_valid_q <= 1'b0;
            out_max_q   <= '0;
            out_idx_q   <= '0;
            out_ties_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            max_q       <= max_d;
            idx_q       <= idx_d;
            ties_q      <= ties_d;
            out_valid_q <= out_valid_d;
            out_max_q   <= out_max_d;
            out_idx_q   <= out_idx_d;
            out_ties_q  <= out_ties_d;
        end
    end

endmodule
